// File: rtl/img_rx_loader.sv
// img_rx_loader: buffers one binary image from UART bytes, then streams it to the CNN core after a strt pulse.
// Define IMG_THRESH_EN for one grey pixel per byte, thresholded against THRESH.
module img_rx_loader #(
  parameter int IMG_PIX = 784,
  parameter int TIMEOUT = 50000
`ifdef IMG_THRESH_EN
  , parameter logic [7:0] THRESH = 8'd128
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       clr_rx_rdy,
  input  logic       bsy,
  output logic       strt,
  output logic       din,
  output logic       loading,
  output logic       ovf,
  output logic       tmo
);
  localparam int CW = $clog2(IMG_PIX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
`ifdef IMG_THRESH_EN
  localparam int STEP = 1;
  logic [STEP-1:0] wdat;
  assign wdat = rx_data >= THRESH;
`else
  localparam int STEP = 8;
  logic [STEP-1:0] wdat;
  assign wdat = rx_data;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_CORE, STREAM} state_t;
  state_t state, state_n;
  logic [CW-1:0] pix_cnt, cnt_n, inc;
  logic [TW-1:0] tmr, tmr_n;
  logic [IMG_PIX-1:0] pix_buf;
  logic take, wr, strt_n, din_n, ovf_n, tmo_n;
  // the cycle after an ack still sees the old rx_rdy level, so it is ignored then
  assign take = rx_rdy & ~clr_rx_rdy;
  assign inc = pix_cnt + CW'(STEP);
  assign loading = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = pix_cnt;
    tmr_n = '0;
    wr = 1'b0;
    strt_n = 1'b0;
    din_n = 1'b0;
    ovf_n = 1'b0;
    tmo_n = 1'b0;
    case (state)
      IDLE, LOAD: begin
        if (take) begin
          wr = 1'b1;
          cnt_n = inc;
          state_n = inc == CW'(IMG_PIX) ? WAIT_CORE : LOAD;
        end else if (state == LOAD && tmr == TW'(TIMEOUT)) begin
          state_n = IDLE;
          cnt_n = '0;
          tmo_n = 1'b1;
        end else if (state == LOAD) tmr_n = tmr + 1'b1;
      end
      WAIT_CORE: begin
        ovf_n = take;
        if (!bsy) begin
          state_n = STREAM;
          strt_n = 1'b1;
          din_n = pix_buf[0];
          cnt_n = CW'(1);
        end
      end
      default: begin
        ovf_n = take;
        if (pix_cnt == CW'(IMG_PIX)) begin
          state_n = IDLE;
          cnt_n = '0;
        end else begin
          din_n = pix_buf[pix_cnt];
          cnt_n = pix_cnt + 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pix_cnt <= '0;
      tmr <= '0;
      clr_rx_rdy <= 1'b0;
      strt <= 1'b0;
      din <= 1'b0;
      ovf <= 1'b0;
      tmo <= 1'b0;
    end else begin
      state <= state_n;
      pix_cnt <= cnt_n;
      tmr <= tmr_n;
      clr_rx_rdy <= take;
      strt <= strt_n;
      din <= din_n;
      ovf <= ovf_n;
      tmo <= tmo_n;
    end
  end
  always_ff @(posedge clk)
    if (wr) pix_buf[pix_cnt +: STEP] <= wdat;
endmodule

// File: tb/tb_img_rx_loader.sv
// tb_img_rx_loader: directed table-driven bench for img_rx_loader (packed mode by default, IMG_THRESH_EN aware).
module tb_img_rx_loader;
  localparam int IMG_PIX = 784;
  localparam int TMO = 300;
`ifdef IMG_THRESH_EN
  localparam int NB = IMG_PIX;
`else
  localparam int NB = IMG_PIX / 8;
`endif
  logic clk = 1'b0, rst = 1'b1, rx_rdy = 1'b0, bsy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic clr_rx_rdy, strt, din, loading, ovf, tmo;
  int errs = 0, checks = 0;

  img_rx_loader #(.IMG_PIX(IMG_PIX), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .bsy(bsy), .strt(strt), .din(din), .loading(loading), .ovf(ovf), .tmo(tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pat;
    int bsy_cyc;
    int ovf_at;
    logic [15:0] head;
  } vec_t;
  vec_t vecs [3];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic pix(input logic [31:0] pat, input int k);
    logic [7:0] b;
`ifdef IMG_THRESH_EN
    b = pat[8*(k%4) +: 8];
    return b >= 8'd128;
`else
    b = pat[8*((k/8)%4) +: 8];
    return b[k%8];
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    rx_data = b;
    rx_rdy = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = clr_rx_rdy;
    end
    rx_rdy = 1'b0;
    if (!ok) check("ack_wait", {31'd0, ok}, 32'd1);
  endtask

  task automatic send_image(input logic [31:0] pat, input int n);
    for (int j = 0; j < n; j++) send_byte(pat[8*(j%4) +: 8]);
  endtask

  task automatic stream(input logic [31:0] pat, input int ovf_at, input logic [15:0] head, input string tag);
    logic [15:0] hg = '0;
    int mism = 0;
    for (int k = 0; k < IMG_PIX; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) check({tag, "_strt_once"}, {31'd0, strt}, 32'd0);
      if (k < 16) hg[k] = din;
      if (din !== pix(pat, k)) mism++;
      if (ovf_at > 0 && k == ovf_at) begin
        rx_data = 8'h5A;
        rx_rdy = 1'b1;
      end
      if (ovf_at > 0 && k == ovf_at + 1) begin
        check({tag, "_ovf_ack"}, {30'd0, clr_rx_rdy, ovf}, 32'd3);
        rx_rdy = 1'b0;
      end
    end
    check({tag, "_head"}, {16'd0, hg}, {16'd0, head});
    check({tag, "_mismatches"}, mism, 0);
    @(negedge clk);
    check({tag, "_end_idle"}, {29'd0, loading, din, strt}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, j;
`ifdef IMG_THRESH_EN
    vecs[0] = '{32'h00FF807F, 0, 0, 16'h6666};
    vecs[1] = '{32'h00FF807F, 100, 0, 16'h6666};
    vecs[2] = '{32'h00FF807F, 0, 50, 16'h6666};
`else
    vecs[0] = '{32'h3CA53CA5, 0, 0, 16'h3CA5};
    vecs[1] = '{32'h00FF00FF, 100, 0, 16'h00FF};
    vecs[2] = '{32'hF00FF00F, 0, 50, 16'hF00F};
`endif
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, clr_rx_rdy, strt, din, loading, ovf, tmo}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send_image(vecs[0].pat, 10);
    check("partial_loading", {31'd0, loading}, 32'd1);
    j = 0;
    for (int i = 1; i <= TMO + 20 && j == 0; i++) begin
      @(negedge clk);
      if (tmo) j = i;
    end
    check("tmo_delay", j, TMO + 1);
    check("tmo_idle", {31'd0, loading}, 32'd0);
    for (int v = 0; v < 3; v++) begin
      bsy = vecs[v].bsy_cyc > 0;
      send_image(vecs[v].pat, NB);
      seen = 0;
      for (int i = 0; i < vecs[v].bsy_cyc; i++) begin
        @(negedge clk);
        seen += int'(strt);
      end
      check($sformatf("v%0d_wait_no_strt", v), seen, 0);
      bsy = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_strt", v), {30'd0, strt, loading}, 32'd3);
      stream(vecs[v].pat, vecs[v].ovf_at, vecs[v].head, $sformatf("v%0d", v));
    end
    send_image(vecs[0].pat, NB);
    @(negedge clk);
    check("rst_img_strt", {31'd0, strt}, 32'd1);
    repeat (300) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_stream", {29'd0, strt, din, loading}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      seen += int'(strt);
    end
    check("rst_no_restart", seen, 0);
    send_image(vecs[0].pat, NB);
    @(negedge clk);
    check("post_rst_strt", {31'd0, strt}, 32'd1);
    stream(vecs[0].pat, 0, vecs[0].head, "post_rst");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
